// File: rtl/mxu_pkg.sv
// Shared constants and helpers for the MXU array and its result-side logic.
// Default array geometry lives here so that every user of mxu_wrapper agrees on it.
package mxu_pkg;

  // Default number of array columns (result lanes).
  localparam int MXU_M = 4;
  // Default width of one result lane; lane j of a row sits at [j*MXU_W +: MXU_W].
  localparam int MXU_W = 4;
  // Default depth of the result FIFO, in aligned rows.
  localparam int MXU_DEPTH = 4;

  // Ceiling log2, usable in constant expressions (port and parameter widths).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mxu_result_fifo.sv
// Synchronous row FIFO for the MXU result collector.
// A push into a full FIFO is accepted only when a pop frees a slot in the same
// cycle; otherwise the row is dropped and the contents stay untouched.
// clear empties the FIFO and wins over push and pop in the same cycle.
module mxu_result_fifo
  import mxu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy, including the full-drop rule.
  always_comb begin
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO state registers; storage is reset so the head reads zero after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mxu_result_collector.sv
// Output-side collector for the MXU systolic array.
// Re-aligns the column-skewed result rows (lane j arrives j cycles after lane 0),
// buffers whole rows in a small FIFO and hands them out over valid/ready.
// Optional feature: define MXU_COLLECT_DROP_CNT_EN to build the saturating
// dropped-row counter behind drop_count; otherwise drop_count reads zero.
module mxu_result_collector
  import mxu_pkg::*;
#(
  parameter int M              = MXU_M,
  parameter int max_data_width = MXU_W,
  parameter int DEPTH          = MXU_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          clear,
  input  logic [M*max_data_width-1:0]   y,
  input  logic                          y_valid,
  output logic [M*max_data_width-1:0]   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [clog2(DEPTH):0]         fifo_count,
  output logic                          overflow,
  output logic [7:0]                    drop_count
);

  localparam int W = max_data_width;

  logic [M*W-1:0] row_aligned;
  logic           row_valid;
  logic           push;
  logic           fifo_full;
  logic           fifo_empty;
  logic           dropped;
  logic           overflow_q, overflow_d;

  // ---------------------------------------------------------------------------
  // Deskew: lane j waits M-1-j enabled cycles so all lanes of a row line up
  // with the last lane, which is taken straight from the array.
  // ---------------------------------------------------------------------------
  for (genvar j = 0; j < M; j++) begin : g_lane
    if (j == M - 1) begin : g_direct
      assign row_aligned[j*W +: W] = y[j*W +: W];
    end else begin : g_delay
      localparam int D = M - 1 - j;
      logic [W-1:0] sh_q [D];
      logic [W-1:0] sh_d [D];

      // Shift this lane by one stage on enabled cycles, hold otherwise.
      always_comb begin
        sh_d = sh_q;
        if (enable) begin
          sh_d[0] = y[j*W +: W];
          for (int k = 1; k < D; k++) sh_d[k] = sh_q[k-1];
        end
      end

      // Lane delay registers; zeroed by reset only, clear leaves data alone.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < D; k++) sh_q[k] <= '0;
        end else begin
          sh_q <= sh_d;
        end
      end

      assign row_aligned[j*W +: W] = sh_q[D-1];
    end
  end

  // The row marker travels M-1 stages, matching the lane 0 delay.
  if (M > 1) begin : g_vld_chain
    logic [M-2:0] vld_q, vld_d;

    // Advance the row marker with the lanes; clear drops any in-flight row.
    always_comb begin
      vld_d = vld_q;
      if (clear) begin
        vld_d = '0;
      end else if (enable) begin
        vld_d[0] = y_valid;
        for (int k = 1; k < M - 1; k++) vld_d[k] = vld_q[k-1];
      end
    end

    // Row marker registers.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) vld_q <= '0;
      else        vld_q <= vld_d;
    end

    assign row_valid = vld_q[M-2];
  end else begin : g_vld_direct
    assign row_valid = y_valid;
  end

  // ---------------------------------------------------------------------------
  // Row buffer
  // ---------------------------------------------------------------------------
  assign push = row_valid & enable;

  mxu_result_fifo #(
    .WIDTH (M*W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .push      (push),
    .push_data (row_aligned),
    .pop       (out_ready),
    .head_data (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = ~fifo_empty;

  // A row is lost when it arrives at a full FIFO that is not popping this cycle.
  assign dropped = push & fifo_full & ~out_ready & ~clear;

  // ---------------------------------------------------------------------------
  // Sticky overflow flag and optional drop counter
  // ---------------------------------------------------------------------------

  // Overflow sets on any drop and is only released by clear or reset.
  always_comb begin
    overflow_d = overflow_q;
    if (clear)        overflow_d = 1'b0;
    else if (dropped) overflow_d = 1'b1;
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) overflow_q <= 1'b0;
    else        overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;

`ifdef MXU_COLLECT_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Count dropped rows, saturating at 255.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clear)                                drop_cnt_d = '0;
    else if (dropped && drop_cnt_q != 8'hFF)  drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_mxu_result_collector.sv
// Testbench for mxu_result_collector with M=4, W=4, DEPTH=4.
// A per-cycle vector table covers the single-row and enable-stall timing;
// hand-written sequences with a skewed row feeder cover the FIFO corner cases.
module tb_mxu_result_collector;

  localparam int M     = 4;
  localparam int W     = 4;
  localparam int DEPTH = 4;

`ifdef MXU_COLLECT_DROP_CNT_EN
  localparam int EXP_DROP = 2;
`else
  localparam int EXP_DROP = 0;
`endif

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          enable    = 1'b0;
  logic          clear     = 1'b0;
  logic [15:0]   y         = '0;
  logic          y_valid   = 1'b0;
  logic          out_ready = 1'b0;
  logic [15:0]   out_data;
  logic          out_valid;
  logic [2:0]    fifo_count;
  logic          overflow;
  logic [7:0]    drop_count;

  always #5 clk = ~clk;

  mxu_result_collector #(
    .M              (M),
    .max_data_width (W),
    .DEPTH          (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .clear      (clear),
    .y          (y),
    .y_valid    (y_valid),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  typedef struct {
    bit          en;
    bit          yv;
    logic [15:0] yin;
    bit          rdy;
    bit          exp_ov;
    logic [15:0] exp_od;
    int          exp_cnt;
  } vec_t;

  vec_t        tbl [14];
  logic [15:0] rows [6];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          tau = 0;
  int          sched_t0 [$];
  logic [15:0] sched_d [$];
  logic [15:0] exp_q [$];
  int          pops = 0;
  int          max_cnt = 0;
  int          first_pop = -1;
  int          last_pop = -1;
  int          s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_row(input int t0, input logic [15:0] d);
    sched_t0.push_back(t0);
    sched_d.push_back(d);
  endtask

  // One cycle: sample outputs at the falling edge, score any pop, then drive
  // the skewed array output for array time tau.
  task automatic step(input bit en, input bit rdy, input bit clr);
    logic [15:0] yy;
    bit          yv;
    logic [15:0] e;
    @(negedge clk);
    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    if (out_valid && rdy && !clr) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pop: got row 0x%0h, expected no row", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("pop_data", out_data, e);
      end
      pops++;
      if (first_pop < 0) first_pop = tau;
      last_pop = tau;
    end
    yy = '0;
    yv = 1'b0;
    for (int i = 0; i < sched_t0.size(); i++) begin
      if (sched_t0[i] == tau) yv = 1'b1;
      for (int j = 0; j < M; j++)
        if (sched_t0[i] + j == tau) yy[j*W +: W] = sched_d[i][j*W +: W];
    end
    enable    = en;
    out_ready = rdy;
    clear     = clr;
    y         = yy;
    y_valid   = yv;
    if (en) tau++;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Single row: lanes 3,5,2,8 skewed, out_valid exactly one cycle at t+4.
    tbl[0]  = '{1, 1, 16'h0003, 1, 0, 16'h0000, 0};
    tbl[1]  = '{1, 0, 16'h0050, 1, 0, 16'h0000, 0};
    tbl[2]  = '{1, 0, 16'h0200, 1, 0, 16'h0000, 0};
    tbl[3]  = '{1, 0, 16'h8000, 1, 0, 16'h0000, 0};
    tbl[4]  = '{1, 0, 16'h0000, 1, 1, 16'h8253, 1};
    tbl[5]  = '{1, 0, 16'h0000, 1, 0, 16'h0000, 0};
    // Enable stall: two frozen cycles mid-row, garbage on y ignored.
    tbl[6]  = '{1, 1, 16'h0001, 1, 0, 16'h0000, 0};
    tbl[7]  = '{1, 0, 16'h0020, 1, 0, 16'h0000, 0};
    tbl[8]  = '{0, 1, 16'hFFFF, 1, 0, 16'h0000, 0};
    tbl[9]  = '{0, 1, 16'hFFFF, 1, 0, 16'h0000, 0};
    tbl[10] = '{1, 0, 16'h0300, 1, 0, 16'h0000, 0};
    tbl[11] = '{1, 0, 16'h4000, 1, 0, 16'h0000, 0};
    tbl[12] = '{1, 0, 16'h0000, 1, 1, 16'h4321, 1};
    tbl[13] = '{1, 0, 16'h0000, 1, 0, 16'h0000, 0};

    rows = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h2468, 16'h1357};

    // Reset state
    #2 reset = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_out_data", out_data, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Table-driven timing vectors
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].exp_ov);
      chk($sformatf("vec%0d_fifo_count", i), fifo_count, tbl[i].exp_cnt);
      if (tbl[i].exp_ov) chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].exp_od);
      enable    = tbl[i].en;
      y_valid   = tbl[i].yv;
      y         = tbl[i].yin;
      out_ready = tbl[i].rdy;
      clear     = 1'b0;
    end

    // Back-to-back rows with out_ready held high
    s = tau;
    for (int r = 0; r < 6; r++) begin
      add_row(s + r, rows[r]);
      exp_q.push_back(rows[r]);
    end
    pops = 0; max_cnt = 0; first_pop = -1; last_pop = -1;
    repeat (12) step(1, 1, 0);
    chk("b2b_pops", pops, 6);
    chk("b2b_span", last_pop - first_pop, 5);
    chk("b2b_max_count", max_cnt, 1);
    chk("b2b_leftover", exp_q.size(), 0);

    // Back-pressure and overflow
    s = tau;
    for (int r = 0; r < 6; r++) add_row(s + r, rows[r]);
    pops = 0;
    repeat (9) step(1, 0, 0);
    settle();
    chk("bp_fifo_count", fifo_count, 4);
    chk("bp_overflow", overflow, 1);
    chk("bp_drop_count", drop_count, EXP_DROP);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_head", out_data, rows[0]);
    for (int r = 0; r < 4; r++) exp_q.push_back(rows[r]);
    repeat (6) step(1, 1, 0);
    settle();
    chk("bp_drain_pops", pops, 4);
    chk("bp_drain_count", fifo_count, 0);
    chk("bp_drain_out_valid", out_valid, 0);
    chk("bp_overflow_sticky", overflow, 1);

    // Clear releases the sticky flags
    step(1, 0, 1);
    settle();
    chk("clr_overflow", overflow, 0);
    chk("clr_drop_count", drop_count, 0);
    chk("clr_fifo_count", fifo_count, 0);

    // Full FIFO with push and pop in the same cycle
    s = tau;
    for (int r = 0; r < 5; r++) add_row(s + r, rows[r]);
    pops = 0;
    repeat (7) step(1, 0, 0);
    settle();
    chk("full_count", fifo_count, 4);
    exp_q.push_back(rows[0]);
    step(1, 1, 0);
    settle();
    chk("full_pp_count", fifo_count, 4);
    chk("full_pp_overflow", overflow, 0);
    chk("full_pp_drop_count", drop_count, 0);
    chk("full_pp_head", out_data, rows[1]);
    for (int r = 1; r < 5; r++) exp_q.push_back(rows[r]);
    repeat (6) step(1, 1, 0);
    settle();
    chk("full_pp_pops", pops, 5);
    chk("full_pp_drain_count", fifo_count, 0);

    // Asynchronous reset with rows buffered and one row in flight
    s = tau;
    add_row(s, rows[0]);
    add_row(s + 1, rows[1]);
    repeat (6) step(1, 0, 0);
    settle();
    chk("rst2_pre_count", fifo_count, 2);
    add_row(tau, rows[2]);
    repeat (2) step(1, 0, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_fifo_count", fifo_count, 0);
    chk("rst2_out_data", out_data, 0);
    @(negedge clk);
    reset = 1'b1;
    pops = 0;
    repeat (8) step(1, 1, 0);
    settle();
    chk("rst2_no_rows_after", pops, 0);
    chk("rst2_out_valid_after", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
